// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the S-memory arbiter.
//   req       requester -> arbiter  request / keep ownership, one bit per requester
//   addr_i    requester -> arbiter  packed addresses, requester i at [i*AW +: AW]
//   wrdata_i  requester -> arbiter  packed write data, requester i at [i*DW +: DW]
//   wren_i    requester -> arbiter  write enables, one bit per requester
//   gnt       arbiter -> requester  one-hot or zero ownership grant
//   rddata    arbiter -> requester  read data, broadcast
//   rdvalid   arbiter -> requester  per-requester read-data valid pulse
//   busy      arbiter -> requester  high while any grant is active
interface s_mem_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] wrdata_i;
    logic [NREQ-1:0]    wren_i;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      rddata;
    logic [NREQ-1:0]    rdvalid;
    logic               busy;

    // Requester side drives requests and access fields
    modport master (
        output req, addr_i, wrdata_i, wren_i,
        input  gnt, rddata, rdvalid, busy
    );

    // Arbiter side returns grants and read data
    modport slave (
        input  req, addr_i, wrdata_i, wren_i,
        output gnt, rddata, rdvalid, busy
    );
endinterface

// File: rtl/s_mem_arbiter.sv
// Round-robin arbiter sharing the single-port 256x8 S-memory among NREQ
// requesters (0 = init, 1 = ksa, 2 = prga). A requester keeps ownership for as
// long as it holds req, so multi-cycle sweeps run uninterrupted. The owner's
// address/data/write-enable are muxed onto the memory port; reads return one
// cycle later with a per-requester valid pulse.
// Ports:
//   clk         system clock, all state on posedge
//   rst         synchronous active-high reset
//   rq          requester bus (slave modport of s_mem_arbiter_if)
//   mem_addr    address to s_mem (combinational from owner)
//   mem_wrdata  write data to s_mem (combinational from owner)
//   mem_wren    write enable to s_mem (combinational, valid access only)
//   mem_q       read data from s_mem, one cycle after address
module s_mem_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    s_mem_arbiter_if.slave      rq,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wrdata,
    output logic                mem_wren,
    input  logic [DW-1:0]       mem_q
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    // Round-robin pointer; while OWNED it is also the owner index
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rdvalid_q, rdvalid_d;

    logic              found;
    logic [IW-1:0]     sel;
    int unsigned       scan_idx;
    logic              access;

    // First requester after ptr (wrapping); owner comes last, so a re-raised
    // req from the previous owner gets no priority
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && rq.req[IW'(scan_idx)]) begin
                found = 1'b1;
                sel   = IW'(scan_idx);
            end
        end
    end

    // A cycle is a real memory access only while the owner still requests
    assign access = |(gnt_q & rq.req);

    // Owner's fields onto the memory port; all zero when nothing is granted
    always_comb begin
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wren   = 1'b0;
        if (state_q == OWNED) begin
            mem_addr   = rq.addr_i[32'(ptr_q)*AW +: AW];
            mem_wrdata = rq.wrdata_i[32'(ptr_q)*DW +: DW];
            mem_wren   = rq.wren_i[ptr_q] & access;
        end
    end

    // Next-state, grant and read-valid logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        rdvalid_d = '0;

        // Read return is tagged with the issuing owner, so it still lands on
        // that requester if ownership moves at the same edge
        if (access && !rq.wren_i[ptr_q]) begin
            rdvalid_d = NREQ'(1) << ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    ptr_d   = sel;
                    gnt_d   = NREQ'(1) << sel;
                end
            end
            OWNED: begin
                if (!rq.req[ptr_q]) begin
                    if (found) begin
                        // Hand over directly, no idle cycle in between
                        ptr_d = sel;
                        gnt_d = NREQ'(1) << sel;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State register; reset points at NREQ-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            gnt_q     <= '0;
            rdvalid_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    assign rq.gnt     = gnt_q;
    assign rq.rdvalid = rdvalid_q;
    assign rq.rddata  = mem_q;
    assign rq.busy    = |gnt_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter with a behavioural 256x8 synchronous S-memory.
module tb_s_mem_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;

    logic          CLOCK_50;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wrdata;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] smem [256];

    int n_cmp;
    int n_err;

    s_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    s_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (CLOCK_50),
        .rst        (rst),
        .rq         (bus),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Single-port synchronous memory: q shows the addressed word one cycle later
    always @(posedge CLOCK_50) begin
        if (mem_wren) smem[mem_addr] <= mem_wrdata;
        mem_q <= smem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        bus.addr_i[r*AW +: AW]   = a;
        bus.wrdata_i[r*DW +: DW] = d;
        bus.wren_i[r]            = we;
    endtask

    initial begin
        int bad;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        mem_q        = '0;
        rst          = 1'b1;
        bus.req      = 3'b111;
        bus.addr_i   = '0;
        bus.wrdata_i = '0;
        bus.wren_i   = 3'b111;

        // Reset held two cycles with all requesting
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt", 32'(bus.gnt), 32'h0);
            check("rst_wren", 32'(mem_wren), 32'h0);
            check("rst_rdvalid", 32'(bus.rdvalid), 32'h0);
            check("rst_busy", 32'(bus.busy), 32'h0);
        end

        // Requester 0 writes s_mem[k]=k for the full range
        rst        = 1'b0;
        bus.req    = 3'b001;
        bus.wren_i = 3'b000;
        set_req(0, 8'h00, 8'h00, 1'b1);
        #1;
        check("idle_addr", 32'(mem_addr), 32'h0);
        check("idle_wren", 32'(mem_wren), 32'h0);
        tick();
        check("sweep_gnt", 32'(bus.gnt), 32'h1);
        check("sweep_busy", 32'(bus.busy), 32'h1);
        for (int k = 0; k < 256; k++) begin
            set_req(0, AW'(k), DW'(k), 1'b1);
            #1;
            if (k == 0 || k == 255) begin
                check("sweep_wren", 32'(mem_wren), 32'h1);
                check("sweep_addr", 32'(mem_addr), 32'(k));
            end
            tick();
        end
        bus.req = 3'b000;
        set_req(0, 8'h00, 8'h00, 1'b0);
        tick();
        check("sweep_release_gnt", 32'(bus.gnt), 32'h0);
        check("sweep_release_busy", 32'(bus.busy), 32'h0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (smem[k] !== 8'(k)) bad++;
        check("sweep_contents_bad", 32'(bad), 32'h0);

        // Requester 1 reads 0x10..0x13 back to back
        bus.req = 3'b010;
        set_req(1, 8'h10, 8'h00, 1'b0);
        tick();
        check("rd_gnt", 32'(bus.gnt), 32'h2);
        for (int k = 16; k < 20; k++) begin
            set_req(1, AW'(k), 8'h00, 1'b0);
            tick();
            check("rd_valid", 32'(bus.rdvalid), 32'h2);
            check("rd_data", 32'(bus.rddata), 32'(k));
        end
        bus.req = 3'b000;
        tick();
        check("rd_end_valid", 32'(bus.rdvalid), 32'h0);
        check("rd_end_gnt", 32'(bus.gnt), 32'h0);

        // Round robin after reset: each reads 4 times then drops
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 3'b111;
        set_req(0, 8'h01, 8'h00, 1'b0);
        set_req(1, 8'h02, 8'h00, 1'b0);
        set_req(2, 8'h03, 8'h00, 1'b0);
        tick();
        for (int r = 0; r < 3; r++) begin
            check("rr_gnt_first", 32'(bus.gnt), 32'(1 << r));
            for (int a = 0; a < 3; a++) begin
                tick();
                check("rr_gnt_hold", 32'(bus.gnt), 32'(1 << r));
            end
            tick();
            check("rr_gnt_release_cycle", 32'(bus.gnt), 32'(1 << r));
            check("rr_last_read_valid", 32'(bus.rdvalid), 32'(1 << r));
            check("rr_busy", 32'(bus.busy), 32'h1);
            bus.req[r] = 1'b0;
            tick();
            check("rr_after_release_valid", 32'(bus.rdvalid), 32'h0);
        end
        check("rr_final_gnt", 32'(bus.gnt), 32'h0);

        // Non-owner write from 2 while 0 reads
        bus.req = 3'b101;
        set_req(0, 8'h20, 8'h00, 1'b0);
        set_req(2, 8'h30, 8'hAA, 1'b1);
        tick();
        check("nonown_gnt", 32'(bus.gnt), 32'h1);
        check("nonown_wren", 32'(mem_wren), 32'h0);
        check("nonown_addr", 32'(mem_addr), 32'h20);
        tick();
        check("nonown_mem", 32'(smem[8'h30]), 32'h30);
        check("nonown_rdvalid", 32'(bus.rdvalid), 32'h1);
        check("nonown_rddata", 32'(bus.rddata), 32'h20);
        bus.req = 3'b100;
        #1;
        check("release_wren", 32'(mem_wren), 32'h0);
        tick();
        check("handover_gnt", 32'(bus.gnt), 32'h4);
        check("handover_wren", 32'(mem_wren), 32'h1);
        check("handover_addr", 32'(mem_addr), 32'h30);
        tick();
        check("handover_rdvalid", 32'(bus.rdvalid), 32'h0);
        check("handover_mem", 32'(smem[8'h30]), 32'hAA);
        bus.req    = 3'b000;
        bus.wren_i = 3'b000;
        tick();
        tick();
        check("handover_idle", 32'(bus.gnt), 32'h0);

        // Reset mid-grant with a read in flight
        bus.req = 3'b010;
        set_req(1, 8'h05, 8'h00, 1'b0);
        tick();
        check("midrst_gnt_before", 32'(bus.gnt), 32'h2);
        rst = 1'b1;
        tick();
        check("midrst_gnt", 32'(bus.gnt), 32'h0);
        check("midrst_rdvalid", 32'(bus.rdvalid), 32'h0);
        rst     = 1'b0;
        bus.req = 3'b110;
        tick();
        check("postrst_gnt", 32'(bus.gnt), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
